// File: rtl/mux_sel_pipe.sv
// Registered N:1 selector with valid/ready handshake.
// A 2-entry skid buffer keeps 1 word/cycle with a registered in_ready.
module mux_sel_pipe #(
    parameter int   WIDTH  = 5,
    parameter int   NUM_IN = 2,
    localparam int  SEL_W  = $clog2(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        in_sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_err,
    output logic                    out_valid,
    input  logic                    out_ready
);

    logic [NUM_IN-1:0] hit;
    logic [WIDTH-1:0]  masked [NUM_IN];
    logic [WIDTH-1:0]  sel_word;
    logic              sel_err;

    // One-hot decode of the select; no hit means an out-of-range index.
    generate
        for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_sel
            assign hit[gi]    = (in_sel == SEL_W'(gi));
            assign masked[gi] = hit[gi] ? in_data[gi*WIDTH +: WIDTH] : '0;
        end
    endgenerate

    always_comb begin
        sel_word = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            sel_word = sel_word | masked[i];
        end
        sel_err = ~|hit;
    end

    logic [WIDTH-1:0] or_data_reg;
    logic             or_err_reg;
    logic             or_valid_reg;
    logic [WIDTH-1:0] sk_data_reg;
    logic             sk_err_reg;
    logic             sk_valid_reg;
    logic             in_ready_reg;

    logic accept;
    logic transfer;

    assign accept   = in_valid & in_ready_reg;
    assign transfer = or_valid_reg & out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            or_data_reg  <= '0;
            or_err_reg   <= 1'b0;
            or_valid_reg <= 1'b0;
            sk_data_reg  <= '0;
            sk_err_reg   <= 1'b0;
            sk_valid_reg <= 1'b0;
            in_ready_reg <= 1'b1;
        end else begin
            if (!or_valid_reg || transfer) begin
                if (sk_valid_reg) begin
                    or_data_reg  <= sk_data_reg;
                    or_err_reg   <= sk_err_reg;
                    or_valid_reg <= 1'b1;
                    // SK refills in the same cycle if a new word arrives.
                    sk_valid_reg <= accept;
                    in_ready_reg <= ~accept;
                    if (accept) begin
                        sk_data_reg <= sel_word;
                        sk_err_reg  <= sel_err;
                    end
                end else if (accept) begin
                    or_data_reg  <= sel_word;
                    or_err_reg   <= sel_err;
                    or_valid_reg <= 1'b1;
                end else begin
                    or_valid_reg <= 1'b0;
                end
            end else if (accept) begin
                // OR stalled: overflow word parks in SK and in_ready drops.
                sk_data_reg  <= sel_word;
                sk_err_reg   <= sel_err;
                sk_valid_reg <= 1'b1;
                in_ready_reg <= 1'b0;
            end
        end
    end

    assign in_ready  = in_ready_reg;
    assign out_data  = or_data_reg;
    assign out_err   = or_err_reg;
    assign out_valid = or_valid_reg;

endmodule

// File: tb/tb_mux_sel_pipe.sv
// Directed and randomised checks of mux_sel_pipe in three configurations.
module tb_mux_sel_pipe;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // NUM_IN=4, WIDTH=5
    logic [19:0] d4;
    logic [1:0]  s4;
    logic        v4, r4, rdy4, err4, ov4;
    logic [4:0]  od4;
    // NUM_IN=3, WIDTH=8
    logic [23:0] d3;
    logic [1:0]  s3;
    logic        v3, r3, rdy3, err3, ov3;
    logic [7:0]  od3;
    // NUM_IN=2, WIDTH=5
    logic [9:0]  d2;
    logic        s2;
    logic        v2, r2, rdy2, err2, ov2;
    logic [4:0]  od2;

    mux_sel_pipe #(.WIDTH(5), .NUM_IN(4)) u4 (
        .clk(clk), .reset(reset), .in_data(d4), .in_sel(s4), .in_valid(v4),
        .in_ready(rdy4), .out_data(od4), .out_err(err4), .out_valid(ov4), .out_ready(r4));
    mux_sel_pipe #(.WIDTH(8), .NUM_IN(3)) u3 (
        .clk(clk), .reset(reset), .in_data(d3), .in_sel(s3), .in_valid(v3),
        .in_ready(rdy3), .out_data(od3), .out_err(err3), .out_valid(ov3), .out_ready(r3));
    mux_sel_pipe #(.WIDTH(5), .NUM_IN(2)) u2 (
        .clk(clk), .reset(reset), .in_data(d2), .in_sel(s2), .in_valid(v2),
        .in_ready(rdy2), .out_data(od2), .out_err(err2), .out_valid(ov2), .out_ready(r2));

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    logic [4:0] q[$];
    logic [4:0] word;
    logic       acc, xfer;
    int         sent, cyc;

    initial begin
        reset = 1'b1;
        d4 = '0; s4 = '0; v4 = 1'b0; r4 = 1'b1;
        d3 = '0; s3 = '0; v3 = 1'b0; r3 = 1'b1;
        d2 = '0; s2 = '0; v2 = 1'b0; r2 = 1'b1;
        step;
        step;
        chk("rst_valid", ov4, 0);
        chk("rst_data", od4, 0);
        chk("rst_err", err4, 0);
        chk("rst_ready", rdy4, 1);
        chk("rst_valid3", ov3, 0);
        chk("rst_valid2", ov2, 0);
        reset = 1'b0;

        // T1: streamed selects, out_ready=1
        d4 = {5'd31, 5'd16, 5'd25, 5'd15};
        v4 = 1'b1; s4 = 2'd0; step;
        chk("t1_d0", od4, 15); chk("t1_v0", ov4, 1); chk("t1_r0", rdy4, 1);
        s4 = 2'd1; step;
        chk("t1_d1", od4, 25); chk("t1_r1", rdy4, 1);
        s4 = 2'd2; step;
        chk("t1_d2", od4, 16); chk("t1_r2", rdy4, 1);
        s4 = 2'd3; step;
        chk("t1_d3", od4, 31); chk("t1_r3", rdy4, 1); chk("t1_e3", err4, 0);
        v4 = 1'b0; step;
        chk("t1_idle", ov4, 0);

        // T2: stall fills OR then SK, third word held off
        r4 = 1'b0; v4 = 1'b1; s4 = 2'd1; step;
        chk("t2_or", od4, 25); chk("t2_rdy_a", rdy4, 1);
        s4 = 2'd2; step;
        chk("t2_or_b", od4, 25); chk("t2_rdy_b", rdy4, 0);
        s4 = 2'd3; step;
        chk("t2_hold", od4, 25); chk("t2_rdy_c", rdy4, 0); chk("t2_v_c", ov4, 1);
        r4 = 1'b1; step;
        chk("t2_sk", od4, 16); chk("t2_rdy_d", rdy4, 1);
        step;
        chk("t2_third", od4, 31); chk("t2_v_e", ov4, 1);
        v4 = 1'b0; step;
        chk("t2_empty", ov4, 0);

        // T3: NUM_IN=3 out-of-range select
        d3 = {8'h0F, 8'h55, 8'hAA};
        v3 = 1'b1; s3 = 2'd3; step;
        chk("t3_oor_d", od3, 8'h00); chk("t3_oor_e", err3, 1); chk("t3_oor_v", ov3, 1);
        s3 = 2'd2; step;
        chk("t3_in_d", od3, 8'h0F); chk("t3_in_e", err3, 0);
        v3 = 1'b0; step;
        chk("t3_idle", ov3, 0);

        // T4: reset while OR and SK are full and a word is offered
        r4 = 1'b0; v4 = 1'b1; s4 = 2'd0; step;
        s4 = 2'd1; step;
        chk("t4_full", rdy4, 0);
        reset = 1'b1; s4 = 2'd2; step;
        reset = 1'b0;
        chk("t4_v", ov4, 0); chk("t4_d", od4, 0); chk("t4_e", err4, 0); chk("t4_rdy", rdy4, 1);
        v4 = 1'b0; r4 = 1'b1; step;
        chk("t4_nostale_a", ov4, 0);
        step;
        chk("t4_nostale_b", ov4, 0);

        // T5: legacy 2:1
        d2 = {5'd31, 5'd3};
        v2 = 1'b1; s2 = 1'b0; step;
        chk("t5_a", od2, 3);
        s2 = 1'b1; step;
        chk("t5_b", od2, 31);
        d2 = '0; s2 = 1'b0; step;
        chk("t5_c", od2, 0); chk("t5_cv", ov2, 1);
        s2 = 1'b1; step;
        chk("t5_d", od2, 0); chk("t5_de", err2, 0);
        v2 = 1'b0; step;
        chk("t5_idle", ov2, 0);

        // T6: random traffic against a queue model
        sent = 0; cyc = 0;
        while ((sent < 200 || q.size() != 0) && cyc < 3000) begin
            v4   = (sent < 200) && ($urandom_range(0, 1) == 1);
            s4   = 2'($urandom_range(0, 3));
            d4   = 20'($urandom);
            r4   = ($urandom_range(0, 1) == 1);
            word = d4[s4*5 +: 5];
            acc  = v4 && (q.size() < 2);
            xfer = (q.size() != 0) && r4;
            step;
            if (xfer) void'(q.pop_front());
            if (acc) begin
                q.push_back(word);
                sent++;
            end
            cyc++;
            chk("t6_valid", ov4, (q.size() != 0));
            chk("t6_ready", rdy4, (q.size() < 2));
            if (q.size() != 0) begin
                chk("t6_data", od4, q[0]);
                chk("t6_err", err4, 0);
            end
        end
        chk("t6_sent", sent, 200);
        chk("t6_drained", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
